// File: rtl/dsp_master_arbiter_pkg.sv
// Shared types for the DSP Wishbone command-port arbiter.
// FSM encoding, default watchdog limit and round-robin index helper.
package dsp_master_arbiter_pkg;

  localparam int DSP_ARB_TIMEOUT = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  function automatic int rr_wrap(
    input int base,
    input int off,
    input int n
  );
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/dsp_rr_arbiter.sv
// Combinational round-robin pick: first request after last_ptr,
// wrapping around, as a one-hot grant plus its index.
module dsp_rr_arbiter
  import dsp_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = rr_wrap(int'(last_ptr), i, NUM_REQ);
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/dsp_master_arbiter.sv
// Shares one Wishbone master command port between NUM_REQ requesters,
// one transfer per grant, with an active/idle watchdog.
module dsp_master_arbiter
  import dsp_master_arbiter_pkg::*;
#(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = DSP_ARB_TIMEOUT
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*aw-1:0] req_adr_i,
  input  logic [NUM_REQ*4-1:0]  req_sel_i,
  input  logic [NUM_REQ-1:0]    req_we_i,
  input  logic [NUM_REQ*dw-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic                  err_o,
  output logic [dw-1:0]         rd_dat_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  input  logic                  clr_timeout_i,
  output logic                  start,
  output logic [aw-1:0]         address,
  output logic [3:0]            selection,
  output logic                  write,
  output logic [dw-1:0]         data_wr,
  input  logic                  active,
  input  logic [dw-1:0]         data_rd
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t               state;
  logic [IW-1:0]        last_ptr;
  logic [IW-1:0]        cur;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 to_hit;

  dsp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req      (req_i),
    .last_ptr (last_ptr),
    .gnt      (pick_gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  assign to_hit = (cnt == CNT_LIM);
  assign busy_o = (state != S_IDLE);

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state     <= S_IDLE;
      last_ptr  <= IW'(NUM_REQ - 1);
      cur       <= '0;
      cnt       <= '0;
      gnt_o     <= '0;
      done_o    <= '0;
      err_o     <= 1'b0;
      rd_dat_o  <= '0;
      timeout_o <= 1'b0;
      start     <= 1'b0;
      address   <= '0;
      selection <= '0;
      write     <= 1'b0;
      data_wr   <= '0;
    end else begin
      // a watchdog set later in this block overrides the clear
      if (clr_timeout_i) timeout_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            state     <= S_ISSUE;
            cur       <= pick_idx;
            gnt_o     <= pick_gnt;
            start     <= 1'b1;
            address   <= req_adr_i[int'(pick_idx)*aw +: aw];
            selection <= req_sel_i[int'(pick_idx)*4 +: 4];
            write     <= req_we_i[pick_idx];
            data_wr   <= req_dat_i[int'(pick_idx)*dw +: dw];
            cnt       <= '0;
          end
        end
        S_ISSUE: begin
          start <= 1'b0;
          state <= S_WAIT_HI;
          cnt   <= '0;
        end
        S_WAIT_HI: begin
          if (active) begin
            state <= S_WAIT_LO;
            cnt   <= '0;
          end else if (to_hit) begin
            state  <= S_DONE;
            done_o <= gnt_o;
            err_o  <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!active) begin
            if (!write) rd_dat_o <= data_rd;
            state  <= S_DONE;
            done_o <= gnt_o;
            cnt    <= '0;
          end else begin
            if (to_hit) timeout_o <= 1'b1;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done_o   <= '0;
          err_o    <= 1'b0;
          gnt_o    <= '0;
          last_ptr <= cur;
          state    <= S_IDLE;
          cnt      <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_master_arbiter.sv
// Directed self-checking bench for dsp_master_arbiter with a
// behavioural Wishbone master model driving active/data_rd.
module tb_dsp_master_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 2;
  localparam int TO = 8;

  logic           wb_clk = 1'b0;
  logic           wb_rst = 1'b0;
  logic [NR-1:0]  req_i = '0;
  logic [NR*AW-1:0] req_adr_i = '0;
  logic [NR*4-1:0]  req_sel_i = '0;
  logic [NR-1:0]  req_we_i = '0;
  logic [NR*DW-1:0] req_dat_i = '0;
  logic [NR-1:0]  gnt_o, done_o;
  logic           err_o, busy_o, timeout_o;
  logic [DW-1:0]  rd_dat_o;
  logic           clr_timeout_i = 1'b0;
  logic           start, write;
  logic [AW-1:0]  address;
  logic [3:0]     selection;
  logic [DW-1:0]  data_wr;
  logic           active = 1'b0;
  logic [DW-1:0]  data_rd = '0;

  int checks = 0;
  int failures = 0;

  logic          m_never = 1'b0;
  int            m_len = 2;
  logic [DW-1:0] m_data = '0;

  int            start_cnt = 0;
  int            done_cnt = 0;
  logic [AW-1:0] s_adr;
  logic [3:0]    s_sel;
  logic          s_we;
  logic [DW-1:0] s_dat;

  logic [NR-1:0] d_gnt, d_done;
  logic          d_err;
  logic [DW-1:0] d_rd;

  dsp_master_arbiter #(
    .dw(DW), .aw(AW), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .req_i(req_i), .req_adr_i(req_adr_i),
    .req_sel_i(req_sel_i), .req_we_i(req_we_i),
    .req_dat_i(req_dat_i), .gnt_o(gnt_o),
    .done_o(done_o), .err_o(err_o),
    .rd_dat_o(rd_dat_o), .busy_o(busy_o),
    .timeout_o(timeout_o),
    .clr_timeout_i(clr_timeout_i),
    .start(start), .address(address),
    .selection(selection), .write(write),
    .data_wr(data_wr), .active(active),
    .data_rd(data_rd)
  );

  always #5 wb_clk = ~wb_clk;

  // bus model: active rises on the start cycle, held m_len cycles
  always begin
    @(negedge wb_clk);
    if (start && !m_never) begin
      active  = 1'b1;
      data_rd = '0;
      repeat (m_len) @(negedge wb_clk);
      active  = 1'b0;
      data_rd = m_data;
    end
  end

  always @(negedge wb_clk) begin
    if (start) begin
      start_cnt++;
      s_adr = address;
      s_sel = selection;
      s_we  = write;
      s_dat = data_wr;
    end
    if (done_o != '0) done_cnt++;
  end

  task automatic set_req(input int k, input logic [AW-1:0] adr,
                         input logic [3:0] sel, input logic we,
                         input logic [DW-1:0] dat);
    req_adr_i[k*AW +: AW] = adr;
    req_sel_i[k*4 +: 4]   = sel;
    req_we_i[k]           = we;
    req_dat_i[k*DW +: DW] = dat;
  endtask

  task automatic do_reset();
    wb_rst = 1'b0;
    req_i  = '0;
    clr_timeout_i = 1'b0;
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b1;
    @(negedge wb_clk);
  endtask

  task automatic wait_done(input int max, output logic ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge wb_clk);
      n++;
      if (done_o != '0) begin
        ok     = 1'b1;
        d_gnt  = gnt_o;
        d_done = done_o;
        d_err  = err_o;
        d_rd   = rd_dat_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt_o, done_o, err_o, start} !== '0) begin
      failures++;
      $display("FAIL reset_ctl got gnt=%b done=%b err=%b start=%b want 0",
               gnt_o, done_o, err_o, start);
    end
    checks++;
    if ({busy_o, timeout_o} !== 2'b00) begin
      failures++;
      $display("FAIL reset_status got busy=%b timeout=%b want 0", busy_o, timeout_o);
    end
    checks++;
    if ({rd_dat_o, data_wr, address, selection, write} !== '0) begin
      failures++;
      $display("FAIL reset_data got rd=%h wr=%h adr=%h want 0",
               rd_dat_o, data_wr, address);
    end
  endtask

  task automatic test_single_read();
    logic ok;
    int n, s0;
    m_len  = 3;
    m_data = 32'hDEADBEEF;
    #1 s0 = start_cnt;
    @(negedge wb_clk);
    set_req(0, 32'h100, 4'hF, 1'b0, 32'h0);
    req_i = 2'b01;
    wait_done(40, ok, n);
    req_i = '0;
    checks++;
    if (!ok || d_done !== 2'b01 || d_gnt !== 2'b01 || d_err !== 1'b0) begin
      failures++;
      $display("FAIL read_done got ok=%b done=%b gnt=%b err=%b want 1/01/01/0",
               ok, d_done, d_gnt, d_err);
    end
    checks++;
    if (d_rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_data got %h want deadbeef", d_rd);
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL read_latency got %0d want 5", n);
    end
    @(negedge wb_clk);
    #1;
    checks++;
    if (start_cnt - s0 != 1 || s_adr !== 32'h100 || s_we !== 1'b0) begin
      failures++;
      $display("FAIL read_cmd got starts=%0d adr=%h we=%b want 1/100/0",
               start_cnt - s0, s_adr, s_we);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL read_idle got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_round_robin();
    logic ok;
    int n, s0;
    logic [NR-1:0] exp;
    m_len  = 2;
    m_data = 32'hA5A50001;
    do_reset();
    #1 s0 = start_cnt;
    @(negedge wb_clk);
    set_req(0, 32'h200, 4'hF, 1'b0, 32'h0);
    set_req(1, 32'h300, 4'hF, 1'b0, 32'h0);
    req_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp = (t % 2 == 0) ? 2'b01 : 2'b10;
      wait_done(40, ok, n);
      if (t == 3) req_i = '0;
      checks++;
      if (!ok || d_gnt !== exp || d_done !== exp) begin
        failures++;
        $display("FAIL rr_order[%0d] got ok=%b gnt=%b done=%b want %b",
                 t, ok, d_gnt, d_done, exp);
      end
      if (t > 0) begin
        checks++;
        if (n != 5) begin
          failures++;
          $display("FAIL rr_spacing[%0d] got %0d want 5", t, n);
        end
      end
    end
    repeat (3) @(negedge wb_clk);
    #1;
    checks++;
    if (start_cnt - s0 != 4) begin
      failures++;
      $display("FAIL rr_starts got %0d want 4", start_cnt - s0);
    end
  endtask

  task automatic test_write();
    logic ok;
    int n;
    m_len  = 2;
    m_data = 32'h5555AAAA;
    @(negedge wb_clk);
    set_req(1, 32'h20, 4'b0011, 1'b1, 32'h1234);
    req_i = 2'b10;
    wait_done(40, ok, n);
    req_i = '0;
    checks++;
    if (!ok || d_gnt !== 2'b10 || d_err !== 1'b0) begin
      failures++;
      $display("FAIL wr_done got ok=%b gnt=%b err=%b want 1/10/0", ok, d_gnt, d_err);
    end
    checks++;
    if (d_rd !== 32'hA5A50001) begin
      failures++;
      $display("FAIL wr_rd_hold got %h want a5a50001", d_rd);
    end
    checks++;
    if (s_adr !== 32'h20 || s_sel !== 4'b0011 || s_we !== 1'b1 || s_dat !== 32'h1234) begin
      failures++;
      $display("FAIL wr_cmd got adr=%h sel=%b we=%b dat=%h want 20/0011/1/1234",
               s_adr, s_sel, s_we, s_dat);
    end
  endtask

  task automatic test_abort();
    logic ok, seen;
    int n;
    m_never = 1'b1;
    @(negedge wb_clk);
    set_req(0, 32'h40, 4'hF, 1'b0, 32'h0);
    req_i = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      if (start) begin
        seen = 1'b1;
        break;
      end
    end
    wait_done(30, ok, n);
    req_i = '0;
    checks++;
    if (!seen || !ok || n != 9) begin
      failures++;
      $display("FAIL abort_timing got start=%b ok=%b cycles=%0d want 1/1/9", seen, ok, n);
    end
    checks++;
    if (d_err !== 1'b1 || d_done !== 2'b01 || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_flags got err=%b done=%b timeout=%b want 1/01/0",
               d_err, d_done, timeout_o);
    end
    checks++;
    if (d_rd !== 32'hA5A50001) begin
      failures++;
      $display("FAIL abort_rd_hold got %h want a5a50001", d_rd);
    end
    m_never = 1'b0;
    m_data  = 32'h13572468;
    @(negedge wb_clk);
    req_i = 2'b01;
    wait_done(40, ok, n);
    req_i = '0;
    checks++;
    if (!ok || d_err !== 1'b0 || d_rd !== 32'h13572468) begin
      failures++;
      $display("FAIL abort_next got ok=%b err=%b rd=%h want 1/0/13572468", ok, d_err, d_rd);
    end
  endtask

  task automatic test_timeout();
    logic ok;
    int n;
    m_len  = 20;
    m_data = 32'h0BADF00D;
    @(negedge wb_clk);
    set_req(1, 32'h80, 4'hF, 1'b0, 32'h0);
    req_i = 2'b10;
    wait_done(60, ok, n);
    req_i = '0;
    checks++;
    if (!ok || d_err !== 1'b0 || d_rd !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL hang_done got ok=%b err=%b rd=%h want 1/0/0badf00d", ok, d_err, d_rd);
    end
    checks++;
    if (timeout_o !== 1'b1) begin
      failures++;
      $display("FAIL hang_flag got %b want 1", timeout_o);
    end
    @(negedge wb_clk);
    clr_timeout_i = 1'b1;
    @(negedge wb_clk);
    clr_timeout_i = 1'b0;
    checks++;
    if (timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL hang_clear got %b want 0", timeout_o);
    end
  endtask

  task automatic test_reset_mid();
    logic ok, seen;
    int n, d0;
    m_len  = 2;
    m_data = 32'h00C0FFEE;
    @(negedge wb_clk);
    set_req(0, 32'h500, 4'hF, 1'b0, 32'h0);
    set_req(1, 32'h600, 4'hF, 1'b0, 32'h0);
    req_i = 2'b01;
    wait_done(40, ok, n);
    req_i = '0;
    checks++;
    if (!ok || d_gnt !== 2'b01) begin
      failures++;
      $display("FAIL mid_pre got ok=%b gnt=%b want 1/01", ok, d_gnt);
    end
    m_len = 10;
    @(negedge wb_clk);
    req_i = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      if (start) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge wb_clk);
    checks++;
    if (!seen || busy_o !== 1'b1 || gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL mid_busy got start=%b busy=%b gnt=%b want 1/1/01", seen, busy_o, gnt_o);
    end
    #2 wb_rst = 1'b0;
    req_i = '0;
    #1;
    d0 = done_cnt;
    checks++;
    if ({start, gnt_o, done_o, busy_o} !== '0) begin
      failures++;
      $display("FAIL mid_reset got start=%b gnt=%b done=%b busy=%b want 0",
               start, gnt_o, done_o, busy_o);
    end
    for (int i = 0; i < 30 && active; i++) @(negedge wb_clk);
    @(negedge wb_clk);
    #1;
    checks++;
    if (active !== 1'b0 || done_cnt != d0) begin
      failures++;
      $display("FAIL mid_nodone got active=%b dones=%0d want 0/0", active, done_cnt - d0);
    end
    @(negedge wb_clk);
    wb_rst = 1'b1;
    m_len  = 2;
    req_i  = 2'b11;
    wait_done(40, ok, n);
    req_i = '0;
    checks++;
    if (!ok || d_gnt !== 2'b01) begin
      failures++;
      $display("FAIL mid_rearb got ok=%b gnt=%b want 1/01", ok, d_gnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_abort();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge wb_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench timeout");
  end

endmodule
